// File: rtl/sdcard_cmd_responder.sv
// sdcard_cmd_responder - card-side SD CMD line engine.
// Deframes 48-bit host commands (CRC7 and end-bit check) and presents index
// and argument. It then serialises an R1/R2/R3 response N_CR SD clocks after
// the command end bit.
// Optional feature macro: SDCMD_ERRCNT_EN. When it is defined, o_err_count is
// a saturating count of errored commands; otherwise o_err_count is tied to 0.
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | line released, waiting for a start bit
// RXCMD    | shifting in the remaining 47 command bits
// WAIT_RSP | good command; waiting for a response request and N_CR
// TXRSP    | driving the response frame, then releasing the line
module sdcard_cmd_responder #(
    parameter int NCR         = 2,
    parameter int RSP_TIMEOUT = 64
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_sdclk_stb,
    input  logic         i_cmd,
    output logic         o_cmd,
    output logic         o_cmd_oe,
    output logic         o_cmd_valid,
    output logic         o_cmd_err,
    output logic [5:0]   o_cmd_index,
    output logic [31:0]  o_cmd_arg,
    input  logic         i_rsp_valid,
    output logic         o_rsp_ready,
    input  logic [1:0]   i_rsp_type,
    input  logic [119:0] i_rsp_data,
    output logic         o_busy,
    output logic [7:0]   o_err_count
);
    localparam int TW = $clog2(RSP_TIMEOUT + 1);
    localparam int NW = $clog2(NCR + 1);

    typedef enum logic [1:0] {IDLE, RXCMD, WAIT_RSP, TXRSP} state_t;

    state_t         r_state;
    logic [7:0]     r_left;     // bits still to receive / transmit
    logic [6:0]     r_crc;
    logic [44:0]    r_rx;       // index, arg, crc once the frame is in
    logic [135:0]   r_sh;       // response payload, MSB goes out first
    logic           r_use_crc;  // R1/R2 append a computed CRC, R3 does not
    logic [7:0]     r_cov;      // payload bits with r_left <= r_cov feed the CRC
    logic           r_acc;      // response request taken, waiting for N_CR
    logic [TW-1:0]  r_tmo;
    logic [NW-1:0]  r_ncr;

    logic           w_rx_err;
    logic           w_tx_bit;
    logic [6:0]     w_tx_crc;
    logic [135:0]   w_tx_sh;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    assign w_rx_err = (r_rx[6:0] != r_crc) || !i_cmd;
    assign o_busy   = (r_state != IDLE);

    // Next response bit: payload, then CRC (R1/R2 only), then the end bit.
    always_comb begin
        w_tx_bit = 1'b1;
        w_tx_sh  = r_sh;
        w_tx_crc = r_crc;
        if (!r_use_crc || r_left > 8'd8) begin
            w_tx_bit = r_sh[135];
            w_tx_sh  = {r_sh[134:0], 1'b0};
            if (r_use_crc && r_left <= r_cov)
                w_tx_crc = crc7_step(r_crc, r_sh[135]);
        end else if (r_left > 8'd1) begin
            w_tx_bit = r_crc[6];
            w_tx_crc = {r_crc[5:0], 1'b0};
        end
    end

    // Command/response sequencer; every bit moves only on an SD clock strobe.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_left      <= '0;
            r_crc       <= '0;
            r_rx        <= '0;
            r_sh        <= '0;
            r_use_crc   <= 1'b0;
            r_cov       <= '0;
            r_acc       <= 1'b0;
            r_tmo       <= '0;
            r_ncr       <= '0;
            o_cmd       <= 1'b1;
            o_cmd_oe    <= 1'b0;
            o_cmd_valid <= 1'b0;
            o_cmd_err   <= 1'b0;
            o_cmd_index <= '0;
            o_cmd_arg   <= '0;
            o_rsp_ready <= 1'b0;
        end else begin
            o_cmd_valid <= 1'b0;
            o_cmd_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_sdclk_stb && !i_cmd) begin
                        r_state <= RXCMD;
                        r_left  <= 8'd47;
                        r_crc   <= '0;     // a zero start bit leaves the CRC at 0
                    end
                end
                RXCMD: begin
                    if (i_sdclk_stb) begin
                        r_left <= r_left - 8'd1;
                        if (r_left == 8'd47 && !i_cmd) begin
                            r_state <= IDLE;  // transmission bit 0: our own echo
                        end else if (r_left == 8'd1) begin
                            o_cmd_valid <= 1'b1;
                            o_cmd_err   <= w_rx_err;
                            o_cmd_index <= r_rx[44:39];
                            o_cmd_arg   <= r_rx[38:7];
                            if (w_rx_err) begin
                                r_state <= IDLE;
                            end else begin
                                r_state     <= WAIT_RSP;
                                o_rsp_ready <= 1'b1;
                                r_acc       <= 1'b0;
                                r_tmo       <= TW'(RSP_TIMEOUT);
                                r_ncr       <= NW'(NCR);
                            end
                        end else begin
                            r_rx <= {r_rx[43:0], i_cmd};
                            if (r_left > 8'd8)
                                r_crc <= crc7_step(r_crc, i_cmd);
                        end
                    end
                end
                WAIT_RSP: begin
                    if (i_sdclk_stb && r_ncr != '0)
                        r_ncr <= r_ncr - NW'(1);
                    if (o_rsp_ready && i_rsp_valid) begin
                        o_rsp_ready <= 1'b0;
                        if (i_rsp_type == 2'd0) begin
                            r_state <= IDLE;
                        end else begin
                            r_acc <= 1'b1;
                            r_crc <= '0;
                            case (i_rsp_type)
                                2'd1: begin
                                    r_sh      <= {2'b00, i_rsp_data[37:0], 96'd0};
                                    r_use_crc <= 1'b1;
                                    r_cov     <= 8'd48;
                                    r_left    <= 8'd48;
                                end
                                2'd2: begin
                                    r_sh      <= {2'b00, 6'h3F, i_rsp_data, 8'd0};
                                    r_use_crc <= 1'b1;
                                    r_cov     <= 8'd128;
                                    r_left    <= 8'd136;
                                end
                                default: begin
                                    r_sh      <= {2'b00, 6'h3F, i_rsp_data[31:0], 7'h7F, 1'b1, 88'd0};
                                    r_use_crc <= 1'b0;
                                    r_cov     <= '0;
                                    r_left    <= 8'd48;
                                end
                            endcase
                        end
                    end else if (r_acc) begin
                        // start bit goes out on strobe NCR, or the first strobe after a late request
                        if (i_sdclk_stb && r_ncr <= NW'(1)) begin
                            r_state  <= TXRSP;
                            o_cmd_oe <= 1'b1;
                            o_cmd    <= w_tx_bit;
                            r_sh     <= w_tx_sh;
                            r_crc    <= w_tx_crc;
                            r_left   <= r_left - 8'd1;
                        end
                    end else if (i_sdclk_stb) begin
                        if (r_tmo == TW'(1)) begin
                            r_state     <= IDLE;
                            o_rsp_ready <= 1'b0;
                        end else begin
                            r_tmo <= r_tmo - TW'(1);
                        end
                    end
                end
                TXRSP: begin
                    if (i_sdclk_stb) begin
                        if (r_left == 8'd0) begin
                            o_cmd_oe <= 1'b0;
                            o_cmd    <= 1'b1;
                            r_acc    <= 1'b0;
                            r_state  <= IDLE;
                        end else begin
                            o_cmd  <= w_tx_bit;
                            r_sh   <= w_tx_sh;
                            r_crc  <= w_tx_crc;
                            r_left <= r_left - 8'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SDCMD_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Saturating count of errored commands, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_err_cnt <= '0;
        else if (o_cmd_err && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign o_err_count = r_err_cnt;
`else
    assign o_err_count = 8'd0;
`endif

endmodule

// File: tb/tb_sdcard_cmd_responder.sv
// Bench for sdcard_cmd_responder: a table of directed commands/responses,
// hand-written corner sequences (echo, timeout, reset mid-response) and
// randomized transactions checked against a bit-queue frame model.
module tb_sdcard_cmd_responder;
    localparam int NCR         = 2;
    localparam int RSP_TIMEOUT = 64;

    logic         i_clk = 1'b0;
    logic         i_reset_n;
    logic         i_sdclk_stb;
    logic         i_cmd;
    logic         o_cmd;
    logic         o_cmd_oe;
    logic         o_cmd_valid;
    logic         o_cmd_err;
    logic [5:0]   o_cmd_index;
    logic [31:0]  o_cmd_arg;
    logic         i_rsp_valid;
    logic         o_rsp_ready;
    logic [1:0]   i_rsp_type;
    logic [119:0] i_rsp_data;
    logic         o_busy;
    logic [7:0]   o_err_count;

    sdcard_cmd_responder #(.NCR(NCR), .RSP_TIMEOUT(RSP_TIMEOUT)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_sdclk_stb(i_sdclk_stb),
        .i_cmd(i_cmd), .o_cmd(o_cmd), .o_cmd_oe(o_cmd_oe),
        .o_cmd_valid(o_cmd_valid), .o_cmd_err(o_cmd_err),
        .o_cmd_index(o_cmd_index), .o_cmd_arg(o_cmd_arg),
        .i_rsp_valid(i_rsp_valid), .o_rsp_ready(o_rsp_ready),
        .i_rsp_type(i_rsp_type), .i_rsp_data(i_rsp_data),
        .o_busy(o_busy), .o_err_count(o_err_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [47:0]  frame;
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic         err;
        logic [1:0]   rtype;
        logic [119:0] rdata;
        int           dly;
    } vec_t;

    vec_t tbl [6];
    int   nvec = 0;
    int   nmis = 0;
    int   errs = 0;
    bit   exp_q[$];
    bit   cap_q[$];
    logic s_valid, s_err, s_oe, s_cmd, s_busy, s_ready;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // CRC7 as the remainder of mod-2 long division by x^7+x^3+1.
    function automatic logic [6:0] crc7_of(input logic [127:0] msg, input int len);
        bit r [0:134];
        logic [6:0] c;
        for (int i = 0; i < 135; i++) r[i] = 1'b0;
        for (int i = 0; i < len; i++) r[i] = msg[len-1-i];
        for (int i = 0; i < len; i++)
            if (r[i]) begin
                r[i]   = 1'b0;
                r[i+4] = ~r[i+4];
                r[i+7] = ~r[i+7];
            end
        for (int i = 0; i < 7; i++) c[6-i] = r[len+i];
        return c;
    endfunction

    function automatic logic [47:0] build_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b01, idx, arg};
        return {m, crc7_of(128'(m), 40), 1'b1};
    endfunction

    function automatic void push_bits(input logic [127:0] v, input int len);
        for (int i = len - 1; i >= 0; i--) exp_q.push_back(v[i]);
    endfunction

    function automatic void build_rsp(input logic [1:0] t, input logic [119:0] d);
        logic [39:0] m;
        exp_q.delete();
        if (t == 2'd1) begin
            m = {2'b00, d[37:0]};
            push_bits(128'(m), 40);
            push_bits(128'(crc7_of(128'(m), 40)), 7);
            exp_q.push_back(1'b1);
        end else if (t == 2'd3) begin
            push_bits(128'({2'b00, 6'h3F, d[31:0], 7'h7F, 1'b1}), 48);
        end else begin
            push_bits(128'({2'b00, 6'h3F}), 8);
            push_bits(128'(d), 120);
            push_bits(128'(crc7_of(128'(d), 120)), 7);
            exp_q.push_back(1'b1);
        end
    endfunction

    // One SD clock: strobe cycle, sample right after its edge, then one idle cycle.
    task automatic stb(input logic c);
        i_cmd       = c;
        i_sdclk_stb = 1'b1;
        @(negedge i_clk);
        i_sdclk_stb = 1'b0;
        s_valid = o_cmd_valid;
        s_err   = o_cmd_err;
        s_oe    = o_cmd_oe;
        s_cmd   = o_cmd;
        s_busy  = o_busy;
        s_ready = o_rsp_ready;
        @(negedge i_clk);
    endtask

    task automatic send_cmd(input logic [47:0] f, input logic [5:0] eidx,
                            input logic [31:0] earg, input logic eerr);
        bit early = 1'b0;
        bit drv   = 1'b0;
        for (int i = 47; i >= 0; i--) begin
            stb(f[i]);
            if (i > 0 && s_valid) early = 1'b1;
            if (s_oe) drv = 1'b1;
        end
        chk("no_early_valid", 32'(early), 32'd0);
        chk("no_drive_rx", 32'(drv), 32'd0);
        chk("cmd_valid", 32'(s_valid), 32'd1);
        chk("cmd_err", 32'(s_err), 32'(eerr));
        chk("cmd_index", 32'(o_cmd_index), 32'(eidx));
        chk("cmd_arg", o_cmd_arg, earg);
        chk("valid_one_cycle", 32'(o_cmd_valid), 32'd0);
    endtask

    task automatic accept(input logic [1:0] t, input logic [119:0] d);
        i_rsp_valid = 1'b1;
        i_rsp_type  = t;
        i_rsp_data  = d;
        @(negedge i_clk);
        i_rsp_valid = 1'b0;
        chk("ready_drops", 32'(o_rsp_ready), 32'd0);
    endtask

    task automatic run_txn(input logic [47:0] f, input logic [5:0] eidx, input logic [31:0] earg,
                           input logic eerr, input logic [1:0] t, input logic [119:0] d, input int dly);
        int n, start, es, bad;
        bit started, done, drv;
        stb(1'b1);
        stb(1'b1);
        send_cmd(f, eidx, earg, eerr);
        if (eerr) begin
            errs++;
            chk("err_idle", 32'(o_busy), 32'd0);
            chk("err_no_ready", 32'(o_rsp_ready), 32'd0);
            drv = 1'b0;
            for (int k = 0; k < 3; k++) begin
                stb(1'b1);
                if (s_oe || s_ready) drv = 1'b1;
            end
            chk("err_no_drive", 32'(drv), 32'd0);
            return;
        end
        chk("ready_up", 32'(o_rsp_ready), 32'd1);
        for (int k = 0; k < dly; k++) stb(1'b1);
        accept(t, d);
        if (t == 2'd0) begin
            chk("none_idle", 32'(o_busy), 32'd0);
            drv = 1'b0;
            for (int k = 0; k < 4; k++) begin
                stb(1'b1);
                if (s_oe) drv = 1'b1;
            end
            chk("none_no_drive", 32'(drv), 32'd0);
            return;
        end
        build_rsp(t, d);
        es = (NCR > dly + 1) ? NCR : dly + 1;
        n = dly; start = -1; started = 1'b0; done = 1'b0;
        cap_q.delete();
        for (int k = 0; k < 300 && !done; k++) begin
            stb(1'b1);
            n++;
            if (s_oe) begin
                if (!started) begin
                    started = 1'b1;
                    start = n;
                end
                cap_q.push_back(s_cmd);
            end else if (started) begin
                done = 1'b1;
                chk("release_high", 32'(s_cmd), 32'd1);
                chk("release_idle", 32'(s_busy), 32'd0);
            end
        end
        if (!done) begin
            nvec++;
            nmis++;
            $display("FAIL rsp_timeout: got no complete response, expected %0d bits", exp_q.size());
            return;
        end
        chk("rsp_start_strobe", 32'(start), 32'(es));
        chk("rsp_len", 32'(cap_q.size()), 32'(exp_q.size()));
        bad = 0;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
            if (cap_q[i] !== exp_q[i]) bad++;
        chk("rsp_bits_wrong", 32'(bad), 32'd0);
    endtask

    initial begin
        int n, cnt;
        bit drv, hit;
        logic [47:0] f;
        logic [127:0] rnd;

        tbl[0] = '{48'h40_0000_0000_95, 6'd0, 32'h0, 1'b0, 2'd0, 120'd0, 0};
        tbl[1] = '{48'h48_0000_01AA_87, 6'd8, 32'h1AA, 1'b0, 2'd1, {82'd0, 6'd8, 32'h1AA}, 0};
        tbl[2] = '{48'h48_0000_01AA_86, 6'd8, 32'h1AA, 1'b1, 2'd1, 120'd0, 0};
        tbl[3] = '{build_cmd(6'd2, 32'h0), 6'd2, 32'h0, 1'b0, 2'd2,
                   120'h0123456789ABCDEF0123456789ABEF, 0};
        tbl[4] = '{build_cmd(6'd41, 32'h40FF8000), 6'd41, 32'h40FF8000, 1'b0, 2'd3,
                   120'h80FF8000, 3};
        tbl[5] = '{build_cmd(6'd55, 32'h1234_0000), 6'd55, 32'h1234_0000, 1'b0, 2'd1,
                   {82'd0, 6'd55, 32'h0000_0120}, 1};

        i_reset_n = 1'b0; i_sdclk_stb = 1'b0; i_cmd = 1'b1;
        i_rsp_valid = 1'b0; i_rsp_type = 2'd0; i_rsp_data = '0;
        repeat (3) @(negedge i_clk);
        chk("rst_cmd", 32'(o_cmd), 32'd1);
        chk("rst_oe", 32'(o_cmd_oe), 32'd0);
        chk("rst_flags", 32'({o_cmd_valid, o_cmd_err, o_rsp_ready, o_busy}), 32'd0);
        chk("rst_index_arg", o_cmd_arg | 32'(o_cmd_index), 32'd0);
        chk("rst_err_count", 32'(o_err_count), 32'd0);
        i_reset_n = 1'b1;
        @(negedge i_clk);

        for (int v = 0; v < 6; v++)
            run_txn(tbl[v].frame, tbl[v].idx, tbl[v].arg, tbl[v].err,
                    tbl[v].rtype, tbl[v].rdata, tbl[v].dly);

        // transmission bit 0 is treated as an echo: silent return to IDLE
        stb(1'b0);
        stb(1'b0);
        chk("echo_idle", 32'(s_busy), 32'd0);
        hit = 1'b0;
        for (int k = 0; k < 6; k++) begin
            stb(1'b1);
            if (s_valid || s_busy) hit = 1'b1;
        end
        chk("echo_silent", 32'(hit), 32'd0);

        // no response request: abandon after RSP_TIMEOUT strobes
        f = build_cmd(6'd13, 32'h0001_0000);
        stb(1'b1);
        send_cmd(f, 6'd13, 32'h0001_0000, 1'b0);
        n = 0; drv = 1'b0;
        for (int k = 0; k < 200; k++) begin
            stb(1'b1);
            n++;
            if (s_oe) drv = 1'b1;
            if (!s_busy) break;
        end
        chk("timeout_strobes", 32'(n), 32'(RSP_TIMEOUT));
        chk("timeout_no_drive", 32'(drv), 32'd0);
        chk("timeout_ready", 32'(o_rsp_ready), 32'd0);
        run_txn(tbl[0].frame, 6'd0, 32'h0, 1'b0, 2'd0, 120'd0, 0);

        // reset in the middle of an R1 response
        stb(1'b1);
        send_cmd(tbl[1].frame, 6'd8, 32'h1AA, 1'b0);
        accept(2'd1, tbl[1].rdata);
        cnt = 0;
        for (int k = 0; k < 100 && cnt < 21; k++) begin
            stb(1'b1);
            if (s_oe) cnt++;
        end
        chk("rst_mid_reached", 32'(cnt), 32'd21);
        #2 i_reset_n = 1'b0;
        #1;
        chk("rst_mid_oe", 32'(o_cmd_oe), 32'd0);
        chk("rst_mid_cmd", 32'(o_cmd), 32'd1);
        chk("rst_mid_busy", 32'(o_busy), 32'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        errs = 0;
        @(negedge i_clk);
        run_txn(tbl[0].frame, 6'd0, 32'h0, 1'b0, 2'd0, 120'd0, 0);

        // randomized commands and responses
        for (int t = 0; t < 40; t++) begin
            logic [5:0]  ridx;
            logic [31:0] rarg;
            logic        rerr;
            int          which;
            ridx = 6'($urandom_range(0, 63));
            rarg = $urandom;
            f    = build_cmd(ridx, rarg);
            rerr = ($urandom_range(0, 3) == 0);
            if (rerr) begin
                which = $urandom_range(0, 7);
                if (which == 7) f[0] = 1'b0;
                else f[1 + which] = ~f[1 + which];
            end
            rnd = {$urandom, $urandom, $urandom, $urandom};
            run_txn(f, ridx, rarg, rerr, 2'($urandom_range(0, 3)), rnd[119:0],
                    $urandom_range(0, 4));
        end

`ifdef SDCMD_ERRCNT_EN
        chk("err_count", 32'(o_err_count), 32'((errs > 255) ? 255 : errs));
`else
        chk("err_count", 32'(o_err_count), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/sdcard_cmd_responder.md
Name: sdcard_cmd_responder

Overview:
Card-side engine for the SD CMD line, the responder to the host's command path. It deframes 48-bit host commands, checks their CRC7 and end bit, and hands index and argument to card-model logic. It then serialises R1/R3/R2 responses back onto CMD after N_CR SD clocks. It is used as a synthesizable card model in the SDIO test harness and as the front end of an FPGA SD-card emulator.

Parameters:
NCR, 2, SD clocks from the command end-bit sample to the first response bit; legal range 2..64.
RSP_TIMEOUT, 64, SD clocks to wait in WAIT_RSP for a response request before abandoning it; must be greater than NCR.

Ports:
i_clk  in  1  system clock; the only clock.
i_reset_n  in  1  asynchronous, active-low reset.
i_sdclk_stb  in  1  one-cycle strobe marking a card-side SD clock edge; all bit sampling and driving happen only on strobes.
i_cmd  in  1  synchronised CMD line.
o_cmd  out  1  CMD drive value.
o_cmd_oe  out  1  CMD output enable.
o_cmd_valid  out  1  one-cycle pulse: a command was received.
o_cmd_err  out  1  qualifies o_cmd_valid: CRC7 mismatch or end bit 0.
o_cmd_index  out  6  command index.
o_cmd_arg  out  32  command argument.
i_rsp_valid  in  1  response request.
o_rsp_ready  out  1  response accepted when valid and ready are both high.
i_rsp_type  in  2  0=none, 1=R1 (48-bit with CRC), 2=R2 (136-bit), 3=R3 (48-bit, CRC field all ones).
i_rsp_data  in  120  R1 uses [37:0] (index, then 32-bit status); R3 uses [31:0]; R2 uses all 120 bits, MSB first.
o_busy  out  1  high in every state except IDLE.
o_err_count  out  8  see Optional Feature.

Behaviour:
- Reset: state IDLE; all outputs 0, except o_cmd=1 (line released high).
- Nothing advances on a cycle without i_sdclk_stb.
- IDLE: on a strobe with i_cmd=0 (start bit), go to RXCMD.
- RXCMD:
  - Shift 47 further bits, MSB first.
  - The transmission bit must be 1. If it is 0, return to IDLE silently with no valid pulse (treat as a host echo).
  - CRC7 (x^7+x^3+1, init 0) covers the first 40 bits.
- On the strobe that samples the end bit:
  - Next i_clk cycle: pulse o_cmd_valid with index and arg.
  - o_cmd_index and o_cmd_arg hold until the next command completes.
  - o_cmd_err=1 if received CRC differs from computed CRC or end bit=0. On error go to IDLE; otherwise go to WAIT_RSP.
- WAIT_RSP:
  - o_rsp_ready=1; a strobe counter starts at the end-bit strobe.
  - Accepting type 0 returns to IDLE.
  - Accepting types 1-3 latches the data. The response start bit is driven after strobe NCR, or after the first strobe following acceptance if acceptance comes later.
  - No acceptance by RSP_TIMEOUT strobes: return to IDLE.
  - o_rsp_ready drops the cycle after acceptance.
- TXRSP:
  - o_cmd_oe=1 and o_cmd is registered, updating the i_clk cycle after each strobe.
  - R1 frame: 0, 0, data[37:0], CRC7 over the preceding 40 bits, 1.
  - R3 frame: 0, 0, 111111, data[31:0], 1111111, 1.
  - R2 frame: 0, 0, 111111, data[119:0], CRC7 over data only, 1.
  - The strobe after the end bit is driven: o_cmd_oe=0, o_cmd=1, go to IDLE.
  - i_cmd is ignored in TXRSP and WAIT_RSP.
- Reset asserted mid-frame: immediate return to the reset state; the line is released within the same cycle (asynchronous).

Optional Feature:
- Macro SDCMD_ERRCNT_EN.
- Defined: o_err_count is an 8-bit saturating count of o_cmd_err pulses, saturating at 255. It is cleared only by reset.
- Undefined: o_err_count is constant 0 and no counter logic exists.

Test Plan:
- Host sends CMD0 (0x40_00000000, CRC byte 0x95) -> o_cmd_valid=1, index=0, arg=0, o_cmd_err=0; respond type 0 -> CMD never driven, o_busy falls.
- Host sends CMD8 (0x48_000001AA, CRC byte 0x87) -> index=8, arg=0x1AA. R1 request with data[37:0]={6'd8, 32'h1AA} -> start bit exactly NCR=2 strobes after the end bit; 48 bits with correct CRC7 checked by the model; oe drops after the end bit.
- CMD8 with the CRC byte corrupted to 0x86 -> o_cmd_err=1, o_rsp_ready never asserts, no drive; o_err_count increments when SDCMD_ERRCNT_EN is defined.
- R2 request with 120-bit pattern 0x0123...EF -> 136 bits observed; bits 133:128 are all ones; CRC7 over data correct.
- No response request -> return to IDLE after exactly 64 strobes, CMD never driven; next command decodes normally.
- Assert i_reset_n low at bit 20 of an R1 response -> o_cmd_oe=0 immediately; a fresh CMD0 afterwards is decoded correctly.
